// File: rtl/leaf_pkg.sv
// Shared packet layout for the leaf TX path: field widths, bit offsets and the
// packed packet struct at the default BFT geometry.
package leaf_pkg;

  localparam int PKT_LEAF_BITS    = 5;
  localparam int PKT_PORT_BITS    = 4;
  localparam int PKT_ADDR_BITS    = 7;
  localparam int PKT_PAYLOAD_BITS = 32;

  localparam int PKT_PAYLOAD_LSB = 0;
  localparam int PKT_ADDR_LSB    = PKT_PAYLOAD_LSB + PKT_PAYLOAD_BITS;
  localparam int PKT_PORT_LSB    = PKT_ADDR_LSB + PKT_ADDR_BITS;
  localparam int PKT_LEAF_LSB    = PKT_PORT_LSB + PKT_PORT_BITS;
  localparam int PKT_VALID_BIT   = PKT_LEAF_LSB + PKT_LEAF_BITS;
  localparam int PKT_BITS        = PKT_VALID_BIT + 1;

  typedef struct packed {
    logic                        valid;
    logic [PKT_LEAF_BITS-1:0]    leaf;
    logic [PKT_PORT_BITS-1:0]    port;
    logic [PKT_ADDR_BITS-1:0]    addr;
    logic [PKT_PAYLOAD_BITS-1:0] payload;
  } leaf_pkt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters, searching upward from
// the port after the last winner, wrapping at N.
module rr_arbiter #(
  parameter int N = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req_i,
  input  logic         en_i,
  output logic [N-1:0] grant_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = 0;
    if (en_i) begin
      for (int off = 0; off < N; off++) begin
        idx = int'(ptr_q) + off;
        if (idx >= N) idx = idx - N;
        if (!found && req_i[idx]) begin
          grant_o[idx] = 1'b1;
          found        = 1'b1;
          ptr_d        = (idx == N - 1) ? '0 : PW'(idx + 1);
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/leaf_tx_packetizer.sv
// Leaf TX packetizer: arbitrates user streams into BFT packets, tracking per-port
// destination, receiver address and receiver credit.
module leaf_tx_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_OUT_PORTS         = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
  input  logic                                    cfg_vld,
  input  logic [NUM_PORT_BITS-1:0]                cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]                cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0]                cfg_dest_port,
  input  logic                                    fs_vld,
  input  logic [NUM_PORT_BITS-1:0]                fs_port,
  input  logic                                    bft_ready,
  input  logic                                    resend,
  output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft
);

  localparam int CW = NUM_ADDR_BITS + 1;
  localparam int SW = NUM_ADDR_BITS + 2;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(1 << NUM_ADDR_BITS);
  localparam logic [SW-1:0] CREDIT_MAX_W = SW'(1 << NUM_ADDR_BITS);
  localparam logic [SW-1:0] FS_INC = SW'(FREESPACE_UPDATE_SIZE);

  logic [CW-1:0]            credit_q [NUM_OUT_PORTS];
  logic [CW-1:0]            credit_d [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_q   [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0] leaf_q   [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dport_q  [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] cfg_valid_q;
  logic [PACKET_BITS-1:0]   pkt_q, pkt_d;

  logic [NUM_OUT_PORTS-1:0] eligible;
  logic [NUM_OUT_PORTS-1:0] grant;
  logic                     arb_en;
  logic [SW-1:0]            sum;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++)
      eligible[i] = vld_user2interface[i] && cfg_valid_q[i] && (credit_q[i] != '0);
  end

  // A held packet blocks new grants until the BFT takes it; resend freezes everything.
  assign arb_en = !resend && (!pkt_q[PACKET_BITS-1] || bft_ready);

  rr_arbiter #(.N(NUM_OUT_PORTS)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_i   (eligible),
    .en_i    (arb_en),
    .grant_o (grant)
  );

  assign ack_interface2user      = grant;
  assign dout_leaf_interface2bft = resend ? '0 : pkt_q;

  always_comb begin
    pkt_d = pkt_q;
    if (|grant) begin
      pkt_d = '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++)
        if (grant[i])
          pkt_d = {1'b1, leaf_q[i], dport_q[i], addr_q[i],
                   din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
    end else if (!resend && bft_ready) begin
      pkt_d = '0;
    end
  end

  // Credit math runs one bit wider so a freespace update can overshoot before clamping.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      sum = {1'b0, credit_q[i]};
      if (fs_vld && (32'(fs_port) == i)) sum = sum + FS_INC;
      if (grant[i])                      sum = sum - SW'(1);
      credit_d[i] = (sum > CREDIT_MAX_W) ? CREDIT_MAX : sum[CW-1:0];
    end
  end

  // NOTE: the per-port tables are small flop arrays, not RAM, so resetting
  // them costs nothing special and guarantees a known start state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_q       <= '0;
      cfg_valid_q <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_q[i] <= CREDIT_MAX;
        addr_q[i]   <= '0;
        leaf_q[i]   <= '0;
        dport_q[i]  <= '0;
      end
    end else begin
      pkt_q <= pkt_d;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_q[i] <= credit_d[i];
        if (grant[i]) addr_q[i] <= addr_q[i] + NUM_ADDR_BITS'(1);
        if (cfg_vld && (32'(cfg_port) == i)) begin
          cfg_valid_q[i] <= 1'b1;
          leaf_q[i]      <= cfg_dest_leaf;
          dport_q[i]     <= cfg_dest_port;
        end
      end
    end
  end

endmodule

// File: tb/tb_leaf_tx_packetizer.sv
// Directed self-checking bench for leaf_tx_packetizer: arbitration order,
// packet format, credit limits and clamping, back-pressure, resend and reset.
module tb_leaf_tx_packetizer;
  import leaf_pkg::*;

  localparam int N = 7;

  logic           clk;
  logic           reset;
  logic [N*32-1:0] din;
  logic [N-1:0]   vld;
  logic [N-1:0]   ack;
  logic           cfg_vld;
  logic [3:0]     cfg_port;
  logic [4:0]     cfg_dest_leaf;
  logic [3:0]     cfg_dest_port;
  logic           fs_vld;
  logic [3:0]     fs_port;
  logic           bft_ready;
  logic           resend;
  logic [48:0]    dout;

  int n_cmp = 0;
  int n_err = 0;
  int acks;
  logic [6:0] addrq[$];

  leaf_tx_packetizer dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .cfg_vld                 (cfg_vld),
    .cfg_port                (cfg_port),
    .cfg_dest_leaf           (cfg_dest_leaf),
    .cfg_dest_port           (cfg_dest_port),
    .fs_vld                  (fs_vld),
    .fs_port                 (fs_port),
    .bft_ready               (bft_ready),
    .resend                  (resend),
    .dout_leaf_interface2bft (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [48:0] mk(input logic [4:0] l, input logic [3:0] p,
                                     input logic [6:0] a, input logic [31:0] d);
    leaf_pkt_t t;
    t.valid   = 1'b1;
    t.leaf    = l;
    t.port    = p;
    t.addr    = a;
    t.payload = d;
    return t;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cfg(input int p, input int l, input int dp);
    cfg_vld       = 1'b1;
    cfg_port      = 4'(p);
    cfg_dest_leaf = 5'(l);
    cfg_dest_port = 4'(dp);
    tick();
    cfg_vld = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Count port-0 acks before each edge and log the address of every packet shown after it.
  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      #1;
      if (ack[0]) acks++;
      @(posedge clk);
      #2;
      if (dout[48]) addrq.push_back(dout[38:32]);
    end
  endtask

  logic [6:0]  exp_ack [6];
  logic [48:0] exp_pkt [6];
  logic [48:0] held;
  int guard;

  initial begin
    reset = 1'b1; din = '0; vld = '0; cfg_vld = 1'b0; cfg_port = '0;
    cfg_dest_leaf = '0; cfg_dest_port = '0; fs_vld = 1'b0; fs_port = '0;
    bft_ready = 1'b0; resend = 1'b0;
    tick();
    tick();
    check("reset_dout", 64'(dout), 64'd0);
    check("reset_ack", 64'(ack), 64'd0);
    reset = 1'b0;

    // Unconfigured port must not be acknowledged.
    vld = 7'b0100000;
    bft_ready = 1'b1;
    #1;
    check("unconfigured_ack", 64'(ack), 64'd0);
    vld = '0;
    tick();

    cfg(0, 1, 0);
    cfg(1, 2, 1);
    cfg(4, 3, 2);
    cfg(2, 5, 3);
    cfg(7, 9, 9);
    cfg(15, 9, 9);

    // Round-robin across ports 0, 1, 4 starting from port 0.
    din[0*32 +: 32] = 32'h100;
    din[1*32 +: 32] = 32'h101;
    din[4*32 +: 32] = 32'h104;
    exp_ack = '{7'h01, 7'h02, 7'h10, 7'h01, 7'h02, 7'h10};
    exp_pkt = '{mk(1, 0, 0, 32'h100), mk(2, 1, 0, 32'h101), mk(3, 2, 0, 32'h104),
                mk(1, 0, 1, 32'h100), mk(2, 1, 1, 32'h101), mk(3, 2, 1, 32'h104)};
    vld = 7'b0010011;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr_ack%0d", k), 64'(ack), 64'(exp_ack[k]));
      @(posedge clk);
      #1;
      check($sformatf("rr_dout%0d", k), 64'(dout), 64'(exp_pkt[k]));
      #1;
    end
    vld = '0;
    #1;
    check("idle_ack", 64'(ack), 64'd0);
    tick();
    check("valid_cleared", 64'(dout[48]), 64'd0);

    // Single word on port 2.
    din[2*32 +: 32] = 32'hDEADBEEF;
    vld = 7'b0000100;
    #1;
    check("p2_ack", 64'(ack), 64'h04);
    @(posedge clk);
    #1;
    check("p2_dout", 64'(dout), 64'(mk(5, 3, 0, 32'hDEADBEEF)));
    vld = '0;
    tick();

    // Back-pressure, then resend replay.
    din[4*32 +: 32] = 32'hCAFE0004;
    vld = 7'b0010000;
    bft_ready = 1'b0;
    #1;
    check("bp_ack", 64'(ack), 64'h10);
    @(posedge clk);
    #1;
    vld = 7'b0000001;
    held = mk(3, 2, 2, 32'hCAFE0004);
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_hold%0d", k), 64'(dout), 64'(held));
      check($sformatf("bp_noack%0d", k), 64'(ack), 64'd0);
      @(posedge clk);
      #1;
    end
    resend = 1'b1;
    bft_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      check($sformatf("resend_dout%0d", k), 64'(dout), 64'd0);
      check($sformatf("resend_ack%0d", k), 64'(ack), 64'd0);
      @(posedge clk);
      #1;
    end
    resend = 1'b0;
    bft_ready = 1'b0;
    #1;
    check("replay_dout", 64'(dout), 64'(held));
    check("replay_noack", 64'(ack), 64'd0);
    bft_ready = 1'b1;
    #1;
    check("drain_ack", 64'(ack), 64'h01);
    @(posedge clk);
    #1;
    check("drain_dout", 64'(dout), 64'(mk(1, 0, 2, 32'h100)));
    vld = '0;
    #1;

    // Credit exhaustion on port 0 and address wrap.
    do_reset();
    cfg(0, 7, 9);
    acks = 0;
    addrq.delete();
    vld = 7'b0000001;
    run(140);
    check("credit_acks128", 64'(acks), 64'd128);
    check("credit_pkts128", 64'(addrq.size()), 64'd128);
    check("addr_127", 64'(addrq[127]), 64'd127);
    fs_vld = 1'b1;
    fs_port = 4'd9;
    run(1);
    fs_port = 4'd7;
    run(1);
    fs_vld = 1'b0;
    run(3);
    check("fs_out_of_range", 64'(acks), 64'd128);
    fs_vld = 1'b1;
    fs_port = 4'd0;
    run(1);
    fs_vld = 1'b0;
    run(80);
    check("fs_acks192", 64'(acks), 64'd192);
    check("fs_pkts192", 64'(addrq.size()), 64'd192);
    check("addr_wrap0", 64'(addrq[128]), 64'd0);
    check("addr_191", 64'(addrq[191]), 64'd63);

    // Simultaneous grant and freespace at credit 100 clamps to 128.
    vld = '0;
    do_reset();
    cfg(0, 1, 1);
    acks = 0;
    addrq.delete();
    vld = 7'b0000001;
    guard = 0;
    while (acks < 28 && guard < 100) begin
      run(1);
      guard++;
    end
    check("reach_credit100", 64'(acks), 64'd28);
    fs_vld = 1'b1;
    fs_port = 4'd0;
    run(1);
    fs_vld = 1'b0;
    run(200);
    check("clamp_total_acks", 64'(acks), 64'd157);

    // Reset in the middle of a stream.
    do_reset();
    cfg(0, 7, 9);
    run(5);
    check("pre_reset_valid", 64'(dout[48]), 64'd1);
    reset = 1'b1;
    #1;
    check("midreset_dout", 64'(dout), 64'd0);
    check("midreset_ack", 64'(ack), 64'd0);
    tick();
    reset = 1'b0;
    cfg(0, 7, 9);
    acks = 0;
    addrq.delete();
    run(140);
    check("post_reset_acks", 64'(acks), 64'd128);
    check("post_reset_addr0", 64'(addrq[0]), 64'd0);
    vld = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/leaf_tx_packetizer.md
LEAF_TX_PACKETIZER -- requirements
Module: leaf_tx_packetizer

Interface
REQ-001 SHALL have parameter PACKET_BITS, default 49, BFT packet width.
REQ-002 SHALL have parameter PAYLOAD_BITS, default 32, user word width.
REQ-003 SHALL have parameter NUM_LEAF_BITS, default 5, destination leaf field width.
REQ-004 SHALL have parameter NUM_PORT_BITS, default 4, destination port field width.
REQ-005 SHALL have parameter NUM_ADDR_BITS, default 7, receiver BRAM address field width.
REQ-006 SHALL have parameter NUM_OUT_PORTS, default 7, user output streams.
REQ-007 SHALL have parameter FREESPACE_UPDATE_SIZE, default 64, credits returned per freespace update.
REQ-008 SHALL have one clock, clk; reset is asynchronous and active-high, named reset.
REQ-009 Ports (name, direction, width, meaning):
- clk  in  1  sole clock.
- reset  in  1  async active-high reset.
- din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  user words; port i at slice i.
- vld_user2interface  in  NUM_OUT_PORTS  word valid per port.
- ack_interface2user  out  NUM_OUT_PORTS  word accepted per port.
- cfg_vld  in  1  destination config write strobe.
- cfg_port  in  NUM_PORT_BITS  local output port being configured.
- cfg_dest_leaf  in  NUM_LEAF_BITS  destination leaf.
- cfg_dest_port  in  NUM_PORT_BITS  destination input port.
- fs_vld  in  1  freespace update strobe.
- fs_port  in  NUM_PORT_BITS  local output port receiving credit.
- bft_ready  in  1  BFT accepts dout this cycle.
- resend  in  1  replay window; suppress new traffic.
- dout_leaf_interface2bft  out  PACKET_BITS  packet: [48] valid, [47:43] leaf, [42:39] port, [38:32] addr, [31:0] payload.

Function
REQ-010 Port i SHALL be eligible when vld[i], cfg_valid[i], and credit[i]!=0 all hold.
REQ-011 Grant SHALL occur when some port is eligible, resend=0, and output register is empty or (valid and bft_ready).
REQ-012 Arbitration SHALL be round-robin, searching from last granted port+1 upward with wrap; after reset, search starts at port 0.
REQ-013 ack_interface2user[i] SHALL be combinational, high only in the grant cycle for port i; at most one bit high per cycle.
REQ-014 Granted word SHALL appear on dout in the next cycle (latency 1), valid=1, leaf/port from cfg[i], addr=addr_ptr[i].
REQ-015 Valid packet with bft_ready=0 SHALL hold unchanged; when bft_ready=1 and no grant, output valid SHALL clear next cycle.
REQ-016 addr_ptr[i] SHALL increment by 1 per grant, wrapping 127->0.
REQ-017 credit[i] (NUM_ADDR_BITS+1 bits) SHALL decrement by 1 on grant and increase by FREESPACE_UPDATE_SIZE on fs_vld with fs_port=i; simultaneous events net +63; result clamps at 128.
REQ-018 fs_vld or cfg_vld with port index >= NUM_OUT_PORTS SHALL be ignored.
REQ-019 cfg_vld SHALL set cfg_valid[cfg_port] and load destination; effective for grants from the next cycle; in-flight packet unaffected.
REQ-020 While resend=1: no grants, all acks 0, dout forced to 0; pending output packet SHALL be retained and re-presented when resend deasserts.

Reset
REQ-021 On reset: dout=0, acks=0, credits=2^NUM_ADDR_BITS (128), addr_ptr=0, cfg_valid=0, rr pointer=port 0; reset mid-packet SHALL discard the pending packet.

Structure
REQ-022 Packet field offsets/widths and the packet field struct SHALL live in shared package leaf_pkg.
REQ-023 Arbitration SHALL be a sub-module rr_arbiter (request vector, enable -> one-hot grant, pointer update).

Verification
REQ-024 Config port 2 -> leaf 5, port 3; drive word 0xDEADBEEF on port 2 -> ack[2] pulse; next cycle dout = {1,5,3,0,0xDEADBEEF}.
REQ-025 Ports 0,1,4 valid continuously, bft_ready=1 -> grant order 0,1,4,0,1,4.
REQ-026 Port 0 sends 128 words, no fs -> ack[0] stops after 128th; fs_vld port 0 -> 64 further words; 128th word addr=127, 129th addr=0.
REQ-027 bft_ready=0 for 5 cycles with valid packet -> dout stable, no acks; resend=1 -> dout=0, packet reappears after resend drops.
REQ-028 Grant and fs_vld same port same cycle at credit 100 -> credit 128 (clamped); assert reset mid-stream -> dout=0, credits 128 immediately.
